seq_chunk_adder: RTL

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder_pkg.sv | 19 +
 rtl/chunk_adder.sv | 26 ++
 rtl/seq_chunk_adder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and defaults for the sequential chunked adder.
package seq_chunk_adder_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CHUNK = 2;

    // Chunk-index counter width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    assign c[0] = ci_i;

    for (genvar g = 0; g < CHUNK; g++) begin : g_fa
        assign s_o[g]   = a_i[g] ^ b_i[g] ^ c[g];
        assign c[g + 1] = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
    end

    assign co_o   = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential adder: processes CHUNK bits of the operands per clock, LSB chunk first.
// Optional subtract mode is compiled in only when SEQ_CHUNK_ADDER_SUB_EN is defined;
// otherwise the sub input is accepted but ignored.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N        = WIDTH / CHUNK;
    localparam int unsigned IW       = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Operand/carry values as they are to be latched at an accepted start.
    logic [WIDTH-1:0] b_in;
    logic             cin_in;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    // a - b is computed as a + ~b + 1; the user carry-in is ignored.
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign b_in       = b;
    assign cin_in     = cin;
    assign unused_sub = sub;
`endif

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_in, c_out, c_msb;

    // Select the operand chunk addressed by the current index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // Chunk 0 takes the latched carry-in; later chunks take the rippled carry.
    assign c_in = (idx_q == '0) ? cin_q : carry_q;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .ci_i   (c_in),
        .s_o    (s_chunk),
        .co_o   (c_out),
        .cmsb_o (c_msb)
    );

    // Next-state logic: operand capture, chunk sequencing and result flags.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cin_d   = cin_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in;
                    cin_d   = cin_in;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    // Results stay held in IDLE; done is a single-cycle pulse.
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (idx_q == IW'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = s_chunk;
                    end
                end
                carry_d = c_out;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = c_out;
                    ovf_d   = c_msb ^ c_out;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cin_q   <= cin_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
